// File: rtl/otp_macro_arbiter.sv
// Round-robin arbiter that serializes NumReq requesters onto one OTP macro port,
// routes each response back to its issuer and guards the macro with a response watchdog.

module otp_macro_arbiter_slot #(
    parameter int IdxW = 2,
    parameter int Idx  = 0
) (
    input  logic            grant_vld,
    input  logic [IdxW-1:0] grant_idx,
    input  logic            rsp_fire,
    input  logic [IdxW-1:0] owner,
    output logic            ready,
    output logic            rsp_valid
);
    localparam logic [IdxW-1:0] Me = IdxW'(Idx);

    assign ready     = grant_vld && (grant_idx == Me);
    assign rsp_valid = rsp_fire && (owner == Me);
endmodule

module otp_macro_arbiter #(
    parameter int NumReq        = 3,
    parameter int Width         = 16,
    parameter int SizeWidth     = 2,
    parameter int AddrWidth     = 10,
    parameter int TimeoutCycles = 1024,
    localparam int IfWidth      = (2**SizeWidth) * Width
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][1:0]            req_cmd_i,
    input  logic [NumReq-1:0][SizeWidth-1:0]  req_size_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NumReq-1:0][IfWidth-1:0]    req_wdata_i,
    output logic [NumReq-1:0]                 rsp_valid_o,
    output logic [IfWidth-1:0]                rsp_rdata_o,
    output logic [2:0]                        rsp_err_o,
    output logic                              otp_valid_o,
    input  logic                              otp_ready_i,
    output logic [1:0]                        otp_cmd_o,
    output logic [SizeWidth-1:0]              otp_size_o,
    output logic [AddrWidth-1:0]              otp_addr_o,
    output logic [IfWidth-1:0]                otp_wdata_o,
    input  logic                              otp_valid_i,
    input  logic [IfWidth-1:0]                otp_rdata_i,
    input  logic [2:0]                        otp_err_i,
    output logic                              timeout_o,
    output logic                              busy_o
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    localparam logic [2:0] NoError    = 3'h0;
    localparam logic [2:0] MacroError = 3'h1;

    // Sparse encoding so a flipped bit lands in ErrorSt rather than a live state.
    typedef enum logic [2:0] {
        IdleSt  = 3'b000,
        IssueSt = 3'b011,
        WaitSt  = 3'b101,
        ErrorSt = 3'b110
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q;
    logic [IdxW-1:0]       owner_q;
    logic [CntW-1:0]       cnt_q;
    logic                  timeout_q;
    logic [1:0]            cmd_q;
    logic [SizeWidth-1:0]  size_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [IfWidth-1:0]    wdata_q;

    logic                  grant_vld;
    logic [IdxW-1:0]       grant_idx;
    logic                  rsp_ok;
    logic                  expire;
    logic                  rsp_fire;

    // Round-robin search starting at rr_ptr; only offered while idle and out of reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            int k;
            k = int'(rr_ptr_q) + i;
            if (k >= NumReq) k = k - NumReq;
            if (!grant_vld && req_valid_i[k]) begin
                grant_vld = 1'b1;
                grant_idx = IdxW'(k);
            end
        end
        if (state_q != IdleSt || !rst_ni) grant_vld = 1'b0;
    end

    // A real response beats a watchdog expiry landing on the same cycle.
    assign rsp_ok   = (state_q == WaitSt) && otp_valid_i;
    assign expire   = (state_q == WaitSt) && !otp_valid_i && (cnt_q == CntMax);
    assign rsp_fire = rsp_ok || expire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IdleSt:  if (grant_vld)   state_d = IssueSt;
            IssueSt: if (otp_ready_i) state_d = WaitSt;
            WaitSt:  if (rsp_fire)    state_d = IdleSt;
            ErrorSt: state_d = ErrorSt;
            default: state_d = ErrorSt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IdleSt;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            cmd_q     <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                owner_q <= grant_idx;
                cmd_q   <= req_cmd_i[grant_idx];
                size_q  <= req_size_i[grant_idx];
                addr_q  <= req_addr_i[grant_idx];
                wdata_q <= req_wdata_i[grant_idx];
            end
            if (state_q == IssueSt && otp_ready_i) begin
                cnt_q <= '0;
            end else if (state_q == WaitSt && cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rsp_fire) begin
                rr_ptr_q <= (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
            end
            if (expire) timeout_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_slot
        otp_macro_arbiter_slot #(
            .IdxW (IdxW),
            .Idx  (i)
        ) u_slot (
            .grant_vld (grant_vld),
            .grant_idx (grant_idx),
            .rsp_fire  (rsp_fire),
            .owner     (owner_q),
            .ready     (req_ready_o[i]),
            .rsp_valid (rsp_valid_o[i])
        );
    end

    // Macro fields are zeroed outside IssueSt so idle and ErrorSt look like reset.
    assign otp_valid_o = (state_q == IssueSt);
    assign otp_cmd_o   = otp_valid_o ? cmd_q   : '0;
    assign otp_size_o  = otp_valid_o ? size_q  : '0;
    assign otp_addr_o  = otp_valid_o ? addr_q  : '0;
    assign otp_wdata_o = otp_valid_o ? wdata_q : '0;

    assign rsp_rdata_o = rsp_ok ? otp_rdata_i : '0;
    assign rsp_err_o   = rsp_ok ? otp_err_i : (expire ? MacroError : NoError);

    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != IdleSt);
endmodule

// File: tb/tb_otp_macro_arbiter.sv
// Directed bench for otp_macro_arbiter: scoreboard queue filled at grant time,
// drained by an independent response monitor.

module tb_otp_macro_arbiter;
    localparam int NumReq = 3;
    localparam int IfW    = 64;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [NumReq-1:0]       req_valid_i;
    logic [NumReq-1:0]       req_ready_o;
    logic [NumReq-1:0][1:0]  req_cmd_i;
    logic [NumReq-1:0][1:0]  req_size_i;
    logic [NumReq-1:0][9:0]  req_addr_i;
    logic [NumReq-1:0][63:0] req_wdata_i;
    logic [NumReq-1:0]       rsp_valid_o;
    logic [IfW-1:0]          rsp_rdata_o;
    logic [2:0]              rsp_err_o;
    logic                    otp_valid_o;
    logic                    otp_ready_i;
    logic [1:0]              otp_cmd_o;
    logic [1:0]              otp_size_o;
    logic [9:0]              otp_addr_o;
    logic [IfW-1:0]          otp_wdata_o;
    logic                    otp_valid_i;
    logic [IfW-1:0]          otp_rdata_i;
    logic [2:0]              otp_err_i;
    logic                    timeout_o;
    logic                    busy_o;

    otp_macro_arbiter #(
        .NumReq        (NumReq),
        .Width         (16),
        .SizeWidth     (2),
        .AddrWidth     (10),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cmd_i   (req_cmd_i),
        .req_size_i  (req_size_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .otp_valid_o (otp_valid_o),
        .otp_ready_i (otp_ready_i),
        .otp_cmd_o   (otp_cmd_o),
        .otp_size_o  (otp_size_o),
        .otp_addr_o  (otp_addr_o),
        .otp_wdata_o (otp_wdata_o),
        .otp_valid_i (otp_valid_i),
        .otp_rdata_i (otp_rdata_i),
        .otp_err_i   (otp_err_i),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] CmdRead  = 2'd0;
    localparam logic [1:0] CmdWrite = 2'd1;
    localparam logic [2:0] NoError  = 3'h0;
    localparam logic [2:0] MacroErr = 3'h1;
    localparam logic [2:0] EccCorr  = 3'h2;

    typedef struct {
        int          req;
        logic [63:0] data;
        logic [2:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every rsp pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_route", 64'(rsp_valid_o), 64'(3'b001 << e.req));
                    chk("rsp_rdata", rsp_rdata_o, e.data);
                    chk("rsp_err",   64'(rsp_err_o), 64'(e.err));
                end
            end else begin
                chk("rsp_idle_data", rsp_rdata_o, 64'd0);
                chk("rsp_idle_err",  64'(rsp_err_o), 64'(NoError));
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_otp_valid", 64'(otp_valid_o), 64'd0);
        chk("rst_otp_addr",  64'(otp_addr_o),  64'd0);
        chk("rst_otp_cmd",   64'(otp_cmd_o),   64'd0);
        chk("rst_otp_wdata", otp_wdata_o,      64'd0);
        chk("rst_rsp_rdata", rsp_rdata_o,      64'd0);
        chk("rst_rsp_err",   64'(rsp_err_o),   64'(NoError));
        chk("rst_timeout",   64'(timeout_o),   64'd0);
        chk("rst_busy",      64'(busy_o),      64'd0);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        otp_ready_i = 1'b0;
        otp_valid_i = 1'b0;
        otp_rdata_i = '0;
        otp_err_i   = NoError;
        exp_q.delete();
        @(negedge clk_i);
        chk_reset_vals();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [1:0] cmd, input logic [1:0] size,
                           input logic [9:0] addr, input logic [63:0] wdata);
        req_cmd_i[i]   = cmd;
        req_size_i[i]  = size;
        req_addr_i[i]  = addr;
        req_wdata_i[i] = wdata;
    endtask

    // One full transaction starting in an idle cycle (called at posedge+1).
    // respond=0 lets the watchdog fire after rsp_wait idle WaitSt cycles.
    task automatic txn(input int g, input int ready_delay, input int rsp_wait, input bit respond,
                       input logic [63:0] rdata, input logic [2:0] err);
        exp_t        e;
        logic [1:0]  e_cmd, e_size;
        logic [9:0]  e_addr;
        logic [63:0] e_wdata;
        e_cmd   = req_cmd_i[g];
        e_size  = req_size_i[g];
        e_addr  = req_addr_i[g];
        e_wdata = req_wdata_i[g];
        @(negedge clk_i);
        chk("grant", 64'(req_ready_o), 64'(3'b001 << g));
        chk("idle_busy", 64'(busy_o), 64'd0);
        e.req  = g;
        e.data = respond ? rdata : 64'd0;
        e.err  = respond ? err : MacroErr;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1 req_valid_i[g] = 1'b0;
        for (int k = 0; k <= ready_delay; k++) begin
            if (k == ready_delay) otp_ready_i = 1'b1;
            @(negedge clk_i);
            chk("issue_valid", 64'(otp_valid_o), 64'd1);
            chk("issue_cmd",   64'(otp_cmd_o),   64'(e_cmd));
            chk("issue_size",  64'(otp_size_o),  64'(e_size));
            chk("issue_addr",  64'(otp_addr_o),  64'(e_addr));
            chk("issue_wdata", otp_wdata_o,      e_wdata);
            chk("issue_no_grant", 64'(req_ready_o), 64'd0);
            @(posedge clk_i);
            #1;
        end
        otp_ready_i = 1'b0;
        for (int k = 0; k < rsp_wait; k++) begin
            @(negedge clk_i);
            chk("wait_no_rsp",   64'(rsp_valid_o), 64'd0);
            chk("wait_otp_idle", 64'(otp_valid_o), 64'd0);
            chk("wait_no_grant", 64'(req_ready_o), 64'd0);
            chk("wait_busy",     64'(busy_o),      64'd1);
            @(posedge clk_i);
            #1;
        end
        if (respond) begin
            otp_valid_i = 1'b1;
            otp_rdata_i = rdata;
            otp_err_i   = err;
        end
        @(negedge clk_i);
        chk("rsp_timing", 64'(rsp_valid_o), 64'(3'b001 << g));
        @(posedge clk_i);
        #1;
        otp_valid_i = 1'b0;
        otp_rdata_i = '0;
        otp_err_i   = NoError;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_cmd_i   = '0;
        req_size_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        otp_ready_i = 1'b0;
        otp_valid_i = 1'b0;
        otp_rdata_i = '0;
        otp_err_i   = NoError;
        #12;
        chk_reset_vals();
        do_reset();

        // Single requester 1, then rr_ptr must point at requester 2.
        set_req(1, CmdRead, 2'd1, 10'h010, 64'd0);
        req_valid_i = 3'b010;
        txn(1, 0, 3, 1'b1, 64'hBEEF_1234, NoError);
        set_req(0, CmdRead, 2'd0, 10'h020, 64'd0);
        set_req(2, CmdWrite, 2'd3, 10'h030, 64'h1122_3344_5566_7788);
        req_valid_i = 3'b111;
        txn(2, 0, 1, 1'b1, 64'h0000_0000_0000_0002, NoError);

        // All three contending: strict 0,1,2 rotation from reset.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 3;
            set_req(g, (k % 2 == 1) ? CmdWrite : CmdRead, 2'(k % 4), 10'(10'h100 + k * 8 + g),
                    64'hC0DE_0000_0000_0000 | 64'(k));
            req_valid_i = 3'b111;
            txn(g, 0, 1, 1'b1, 64'hA000_0000_0000_0000 | 64'(k), (k == 4) ? EccCorr : NoError);
        end

        // Macro back-pressure for 5 cycles, minimum-latency response.
        do_reset();
        set_req(0, CmdWrite, 2'd2, 10'h3FF, 64'hDEAD_BEEF_CAFE_F00D);
        set_req(2, CmdRead, 2'd0, 10'h001, 64'd0);
        req_valid_i = 3'b101;
        txn(0, 5, 0, 1'b1, 64'h5555_AAAA_5555_AAAA, NoError);

        // Response coincides with the expiry cycle: forwarded, no timeout.
        do_reset();
        set_req(0, CmdRead, 2'd1, 10'h044, 64'd0);
        req_valid_i = 3'b001;
        txn(0, 0, 7, 1'b1, 64'h0123_4567_89AB_CDEF, EccCorr);
        @(negedge clk_i);
        chk("edge_no_timeout", 64'(timeout_o), 64'd0);

        // Hung macro: MacroError on the 8th WaitSt cycle, sticky flag, next request served.
        do_reset();
        set_req(2, CmdRead, 2'd3, 10'h077, 64'd0);
        req_valid_i = 3'b100;
        txn(2, 0, 7, 1'b0, 64'd0, NoError);
        @(negedge clk_i);
        chk("timeout_set", 64'(timeout_o), 64'd1);
        @(posedge clk_i);
        #1;
        set_req(0, CmdRead, 2'd0, 10'h005, 64'd0);
        req_valid_i = 3'b001;
        txn(0, 0, 2, 1'b1, 64'h0000_0000_FACE_0FF0, NoError);
        @(negedge clk_i);
        chk("timeout_sticky", 64'(timeout_o), 64'd1);

        // Reset mid-WaitSt: response dropped, rr_ptr back to 0.
        do_reset();
        set_req(0, CmdRead, 2'd0, 10'h011, 64'd0);
        req_valid_i = 3'b001;
        txn(0, 0, 0, 1'b1, 64'h11, NoError);
        set_req(1, CmdRead, 2'd1, 10'h022, 64'd0);
        req_valid_i = 3'b010;
        @(negedge clk_i);
        chk("pre_rst_grant", 64'(req_ready_o), 64'b010);
        @(posedge clk_i);
        #1 req_valid_i = '0;
        otp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 otp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_vals();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        otp_valid_i = 1'b1;
        otp_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk_i);
        chk("late_rsp_dropped", 64'(rsp_valid_o), 64'd0);
        chk("late_rsp_data",    rsp_rdata_o,      64'd0);
        chk("late_busy",        64'(busy_o),      64'd0);
        @(posedge clk_i);
        #1 otp_valid_i = 1'b0;
        otp_rdata_i = '0;
        set_req(0, CmdRead, 2'd0, 10'h033, 64'd0);
        set_req(1, CmdRead, 2'd0, 10'h034, 64'd0);
        set_req(2, CmdRead, 2'd0, 10'h035, 64'd0);
        req_valid_i = 3'b111;
        txn(0, 0, 1, 1'b1, 64'h77, NoError);

        @(negedge clk_i);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/otp_macro_arbiter.md
# otp_macro_arbiter

Round-robin arbiter and sequencer sharing one OTP macro command/response port between `NumReq` requesters, such as DAI, LCI and partition-init FSMs. It sits between the OTP controller's requesting FSMs and the macro wrapper and allows only one macro transaction in flight. It routes each macro response back to the requester that issued the command. A response watchdog converts a hung macro into a `MacroError` response and a sticky timeout flag.

## Interface
- `NumReq`, 3: number of requesters (2..8).
- `Width`, 16: native OTP word width.
- `SizeWidth`, 2: size field width; interface data width `IfWidth` = 2**SizeWidth*Width.
- `AddrWidth`, 10: macro word address width.
- `TimeoutCycles`, 1024: cycles allowed from macro command acceptance to macro response (≥2).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in NumReq: per-requester command valid.
- `req_ready_o` out NumReq: per-requester command accepted (one-hot pulse).
- `req_cmd_i` in NumReq×cmd_e: command (caliptra_prim_otp_pkg encoding).
- `req_size_i` in NumReq×SizeWidth: native words minus 1.
- `req_addr_i` in NumReq×AddrWidth: start address.
- `req_wdata_i` in NumReq×IfWidth: write data.
- `rsp_valid_o` out NumReq: one-hot response pulse to the owning requester.
- `rsp_rdata_o` out IfWidth: response data, broadcast to all requesters.
- `rsp_err_o` out err_e: response error, broadcast to all requesters.
- `otp_valid_o` out 1: macro command valid.
- `otp_ready_i` in 1: macro command ready.
- `otp_cmd_o` out cmd_e: macro command.
- `otp_size_o` out SizeWidth: macro size.
- `otp_addr_o` out AddrWidth: macro address.
- `otp_wdata_o` out IfWidth: macro write data.
- `otp_valid_i` in 1: macro response valid.
- `otp_rdata_i` in IfWidth: macro response data.
- `otp_err_i` in err_e: macro response error.
- `timeout_o` out 1: sticky flag, set on watchdog expiry.
- `busy_o` out 1: state is not IdleSt.

## Operation
- FSM states:
  - IdleSt:
    - If any `req_valid_i` is set, grant `g` = first set bit at or after `rr_ptr`, wrapping at NumReq.
    - Assert `req_ready_o[g]` combinationally in the same cycle.
    - Latch cmd/size/addr/wdata and `g`, then go to IssueSt.
  - IssueSt:
    - `otp_valid_o`=1 with the latched fields, held stable.
    - On `otp_ready_i`, go to WaitSt and clear the watchdog.
  - WaitSt:
    - On `otp_valid_i`: `rsp_valid_o[g]`=1 that cycle, `rsp_rdata_o`=`otp_rdata_i`, `rsp_err_o`=`otp_err_i`; set `rr_ptr`=(g+1) mod NumReq; go to IdleSt.
  - ErrorSt: unreachable except by glitch or an illegal encoding. Outputs are held idle there. No exit except reset.
- Watchdog:
  - The counter runs only in WaitSt and saturates.
  - If it reaches TimeoutCycles-1 without `otp_valid_i`:
    - drive `rsp_valid_o[g]`=1 with `rsp_err_o`=MacroError and `rsp_rdata_o`=0;
    - set `timeout_o`, which stays set until reset;
    - advance `rr_ptr` and return to IdleSt.
- Arbitration:
  - Commands pass through unmodified.
  - The arbiter does no command legality checking.
  - A requester must hold `req_valid_i` and its fields stable until `req_ready_o`.
- Width rules: `rr_ptr` is $clog2(NumReq) bits; counter width is $clog2(TimeoutCycles).

## Timing
- Reset values:
  - all `req_ready_o`, `rsp_valid_o`, `otp_valid_o`, `timeout_o`, `busy_o` = 0;
  - `otp_*` fields = 0; `rsp_rdata_o`=0; `rsp_err_o`=NoError;
  - `rr_ptr`=0; state=IdleSt.
- Accept latency: `req_ready_o` arrives in the same cycle as `req_valid_i` when IdleSt.
- `otp_valid_o` is asserted the following cycle.
- Minimum turnaround is 3 cycles: accept, issue (with ready), response.
- Next accept is possible the cycle after the response.
- `rsp_valid_o` is a single-cycle pulse. `rsp_rdata_o`/`rsp_err_o` are valid only while some `rsp_valid_o` bit is high; otherwise they are 0/NoError.
- `otp_valid_i` outside WaitSt is ignored with no effect.
- A response in the same cycle as watchdog expiry wins: it is forwarded normally and `timeout_o` is not set.
- Asynchronous reset mid-transaction:
  - returns immediately to the reset values;
  - the in-flight response is dropped;
  - the requester receives no `rsp_valid_o`.
- Requesters stay fully serialized: no new grant is issued while `busy_o`=1.

## Test plan
- Single requester 1: Read, addr 0x10, size 1. Macro responds 4 cycles after ready with rdata 0xBEEF_1234 and NoError. Expect `req_ready_o`=3'b010, `otp_addr_o`=0x10, `rsp_valid_o`=3'b010 with data 0xBEEF_1234, `rr_ptr`=2.
- All three requesters valid continuously, 6 transactions. Expect grant order 0,1,2,0,1,2 and each response routed only to its own requester.
- Macro `otp_ready_i` held low 5 cycles. Expect `otp_valid_o` and fields stable across all 5 cycles, and no second grant.
- TimeoutCycles=8 with no macro response. Expect `rsp_valid_o[g]` on the 8th WaitSt cycle with MacroError and rdata 0, `timeout_o`=1 sticky, and the next request still served.
- Response arriving exactly on the expiry cycle. Expect the macro data and error forwarded, `timeout_o`=0.
- Assert `rst_ni` low during WaitSt, then deassert and deliver a late `otp_valid_i`. Expect no `rsp_valid_o`, all outputs at reset values, and `rr_ptr`=0.
